// File: rtl/ahb_timer_slave.sv
// AHB-Lite responder holding the control registers of a 32-bit reloading down-counter timer.
// Build option: define TIMER_PRESCALER_EN to add the PRESC register and tick prescaler at 0x10.
module ahb_timer_slave #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 12
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  output logic              IRQ
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_VALUE  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
`ifdef TIMER_PRESCALER_EN
  localparam logic [2:0] OFF_PRESC  = 3'd4;
  localparam logic [2:0] LAST_IDX   = 3'd4;
`else
  localparam logic [2:0] LAST_IDX   = 3'd3;
`endif
  localparam logic [1:0] WAIT_INIT  = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t      state;
  logic [1:0]  wait_cnt;
  logic        dp_act;
  logic        dp_wr;
  logic [2:0]  dp_idx;

  logic        accept;
  logic        complete;
  logic        wr_fire;
  logic        rd_fire;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic [31:0] rd_word;

  logic        en;
  logic        ie;
  logic        oneshot;
  logic [31:0] load_q;
  logic [31:0] value_q;
  logic        if_q;
  logic        tick;
  logic        expire;
`ifdef TIMER_PRESCALER_EN
  logic        wr_presc;
  logic [15:0] presc;
  logic [15:0] pcnt;
`endif

  logic unused_htrans;
  assign unused_htrans = HTRANS[0];

  function automatic logic is_legal(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    logic mapped;
    mapped = (addr[ADDR_W-1:5] == '0) && (addr[4:2] <= LAST_IDX);
    return mapped && (size == 3'b010) && (addr[1:0] == 2'b00);
  endfunction

  assign accept = HSEL && HTRANS[1] && HREADY;

  // Data-phase sequencer: one OKAY or two-cycle ERROR response per accepted address phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      dp_act   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          state  <= ST_IDLE;
          dp_act <= 1'b0;
          if (accept) begin
            dp_wr  <= HWRITE;
            dp_idx <= HADDR[4:2];
            if (!is_legal(HADDR, HSIZE)) begin
              state <= ST_ERR1;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              dp_act <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state  <= ST_IDLE;
            dp_act <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

  assign complete  = (state == ST_IDLE) && dp_act;
  assign wr_fire   = complete && dp_wr;
  assign rd_fire   = complete && !dp_wr;
  assign wr_ctrl   = wr_fire && (dp_idx == OFF_CTRL);
  assign wr_load   = wr_fire && (dp_idx == OFF_LOAD);
  assign wr_status = wr_fire && (dp_idx == OFF_STATUS);

  always_comb begin
    rd_word = '0;
    case (dp_idx)
      OFF_CTRL:   rd_word = {29'd0, oneshot, ie, en};
      OFF_LOAD:   rd_word = load_q;
      OFF_VALUE:  rd_word = value_q;
      OFF_STATUS: rd_word = {31'd0, if_q};
`ifdef TIMER_PRESCALER_EN
      OFF_PRESC:  rd_word = {16'd0, presc};
`endif
      default:    rd_word = '0;
    endcase
  end

  assign HRDATA = rd_fire ? rd_word : '0;

`ifdef TIMER_PRESCALER_EN
  assign wr_presc = wr_fire && (dp_idx == OFF_PRESC);

  // Prescaler restarts whenever the timer is stopped or the divisor changes
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      if (wr_presc) presc <= HWDATA[15:0];
      if (!en || wr_presc || (pcnt == presc)) pcnt <= '0;
      else                                    pcnt <= pcnt + 16'd1;
    end
  end

  assign tick = en && (pcnt == presc);
`else
  assign tick = en;
`endif

  assign expire = tick && (value_q == 32'd0);

  // Timer state: bus writes take priority over the tick, except a timer set of IF beats W1C
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      oneshot <= 1'b0;
      load_q  <= '0;
      value_q <= '0;
      if_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en      <= HWDATA[0];
        ie      <= HWDATA[1];
        oneshot <= HWDATA[2];
      end else if (expire && oneshot) begin
        en <= 1'b0;
      end

      if (wr_load) load_q <= HWDATA;

      if (wr_load) begin
        value_q <= HWDATA;
      end else if (tick) begin
        if (value_q != 32'd0) value_q <= value_q - 32'd1;
        else if (!oneshot)    value_q <= load_q;
      end

      if (expire)                       if_q <= 1'b1;
      else if (wr_status && HWDATA[0])  if_q <= 1'b0;
    end
  end

  assign IRQ = if_q && ie;

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Self-checking bench for ahb_timer_slave: one zero-wait and one two-wait-state instance.
module tb_ahb_timer_slave;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  hsel;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        rdy  [2];
  logic [31:0] rdat [2];
  logic        rsp  [2];
  logic        irq  [2];

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc    = 0;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  ahb_timer_slave #(.WAIT_STATES(0), .ADDR_W(12)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(rdy[0]),
    .HREADYOUT(rdy[0]), .HRDATA(rdat[0]), .HRESP(rsp[0]), .IRQ(irq[0])
  );

  ahb_timer_slave #(.WAIT_STATES(2), .ADDR_W(12)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(rdy[1]),
    .HREADYOUT(rdy[1]), .HRDATA(rdat[1]), .HRESP(rsp[1]), .IRQ(irq[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Closed-form timer after n ticks from VALUE=v0 with reload l
  function automatic void tmodel(input int unsigned v0, input int unsigned l, input bit os,
                                 input int unsigned n, output int unsigned v,
                                 output bit fired, output bit en);
    en = 1'b1;
    fired = 1'b0;
    if (n <= v0) begin
      v = v0 - n;
    end else begin
      fired = 1'b1;
      if (os) begin
        v = 0;
        en = 1'b0;
      end else begin
        v = l - ((n - v0 - 1) % (l + 1));
      end
    end
  endfunction

  task automatic xfer(input int inst, input bit wr, input logic [11:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int low,
                      output bit rsp_low, output bit rsp_end, output int unsigned rcyc);
    bit done;
    done = 1'b0;
    low = 0;
    rsp_low = 1'b0;
    rsp_end = 1'b0;
    rdata = '0;
    rcyc = 0;
    hsel = '0;
    hsel[inst] = 1'b1;
    HTRANS = 2'b10;
    HADDR = addr;
    HWRITE = wr;
    HSIZE = size;
    @(posedge HCLK);
    #1;
    hsel = '0;
    HTRANS = 2'b00;
    HWDATA = wdata;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge HCLK);
      if (rdy[inst]) begin
        done = 1'b1;
        rdata = rdat[inst];
        rsp_end = rsp[inst];
        rcyc = cyc;
      end else begin
        low++;
        if (rsp[inst]) rsp_low = 1'b1;
      end
    end
    check("xfer_timeout", 32'(done), 32'd1);
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr32(input int inst, input logic [11:0] addr, input logic [31:0] data,
                      output int unsigned commit);
    logic [31:0] d;
    int low;
    bit rl, re;
    int unsigned rc;
    xfer(inst, 1'b1, addr, 3'b010, data, d, low, rl, re, rc);
    commit = cyc;
    check("wr_wait", 32'(low), (inst == 1) ? 32'd2 : 32'd0);
    check("wr_resp", {30'd0, rl, re}, 32'd0);
  endtask

  task automatic rd32(input int inst, input logic [11:0] addr, output logic [31:0] d,
                      output int unsigned rc);
    int low;
    bit rl, re;
    xfer(inst, 1'b0, addr, 3'b010, 32'h0, d, low, rl, re, rc);
    check("rd_wait", 32'(low), (inst == 1) ? 32'd2 : 32'd0);
    check("rd_resp", {30'd0, rl, re}, 32'd0);
  endtask

  task automatic err_xfer(input string tag, input bit wr, input logic [11:0] addr,
                          input logic [2:0] size);
    logic [31:0] d;
    int low;
    bit rl, re;
    int unsigned rc;
    xfer(0, wr, addr, size, 32'hDEAD_BEEF, d, low, rl, re, rc);
    check({tag, "_low"}, 32'(low), 32'd1);
    check({tag, "_resp"}, {30'd0, rl, re}, 32'b11);
    check({tag, "_rdata"}, d, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, required finish before 300us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int unsigned c, ce, rc, v, lval, w;
    bit f, e, os;

    HRESET = 1'b1;
    hsel = '0;
    HTRANS = 2'b00;
    HADDR = '0;
    HWRITE = 1'b0;
    HSIZE = 3'b010;
    HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    @(negedge HCLK);
    for (int i = 0; i < 2; i++) begin
      check("rst_hreadyout", 32'(rdy[i]), 32'd1);
      check("rst_hresp", 32'(rsp[i]), 32'd0);
      check("rst_hrdata", rdat[i], 32'd0);
      check("rst_irq", 32'(irq[i]), 32'd0);
    end
    for (int a = 0; a < 4; a++) begin
      rd32(0, 12'(a * 4), d, rc);
      check("rst_reg", d, 32'd0);
    end

    wr32(0, 12'h004, 32'h0000_0005, c);
    rd32(0, 12'h008, d, rc);
    check("load_to_value", d, 32'h5);

    rd32(1, 12'h000, d, rc);
    check("ws2_ctrl", d, 32'd0);
    wr32(1, 12'h004, 32'h0000_1234, c);
    rd32(1, 12'h004, d, rc);
    check("ws2_load", d, 32'h1234);

    // Periodic LOAD=3: IRQ on the 4th tick, VALUE follows the reload sequence
    wr32(0, 12'h004, 32'd3, c);
    wr32(0, 12'h000, 32'h3, ce);
    for (int i = 0; i <= 4; i++) begin
      @(negedge HCLK);
      check("irq_rise", 32'(irq[0]), 32'(i >= 4));
    end
    rd32(0, 12'h008, d, rc);
    tmodel(3, 3, 1'b0, rc - ce, v, f, e);
    check("periodic_value", d, v);
    rd32(0, 12'h00C, d, rc);
    check("periodic_if", d, 32'd1);
    wr32(0, 12'h000, 32'h0, c);
    wr32(0, 12'h00C, 32'h1, c);
    rd32(0, 12'h00C, d, rc);
    check("periodic_clr", d, 32'd0);

    wr32(0, 12'h004, 32'd2, c);
    wr32(0, 12'h000, 32'h7, ce);
    repeat (10) @(posedge HCLK);
    #1;
    rd32(0, 12'h000, d, rc);
    check("oneshot_ctrl", d, 32'h6);
    rd32(0, 12'h008, d, rc);
    check("oneshot_value", d, 32'd0);
    rd32(0, 12'h00C, d, rc);
    check("oneshot_if", d, 32'd1);
    wr32(0, 12'h00C, 32'h1, c);
    repeat (10) @(posedge HCLK);
    #1;
    rd32(0, 12'h00C, d, rc);
    check("oneshot_nofire", d, 32'd0);
    @(negedge HCLK);
    check("oneshot_irq", 32'(irq[0]), 32'd0);

    wr32(0, 12'h000, 32'h0, c);
    wr32(0, 12'h004, 32'hA5A5_0001, c);
    err_xfer("err_byte", 1'b1, 12'h004, 3'b000);
    err_xfer("err_unmapped", 1'b0, 12'h020, 3'b010);
    err_xfer("err_misalign", 1'b1, 12'h006, 3'b010);
    err_xfer("err_highaddr", 1'b1, 12'h104, 3'b010);
`ifndef TIMER_PRESCALER_EN
    err_xfer("err_presc", 1'b0, 12'h010, 3'b010);
`endif
    rd32(0, 12'h004, d, rc);
    check("err_load_kept", d, 32'hA5A5_0001);
    rd32(0, 12'h008, d, rc);
    check("err_value_kept", d, 32'hA5A5_0001);

    // W1C landing on the firing edge: the set must win
    wr32(0, 12'h004, 32'd5, c);
    wr32(0, 12'h000, 32'h3, ce);
    repeat (4) @(posedge HCLK);
    #1;
    wr32(0, 12'h00C, 32'h1, c);
    @(negedge HCLK);
    check("w1c_collide_irq", 32'(irq[0]), 32'd1);
    rd32(0, 12'h00C, d, rc);
    check("w1c_collide_if", d, 32'd1);
    wr32(0, 12'h000, 32'h0, c);
    wr32(0, 12'h00C, 32'h1, c);
    rd32(0, 12'h00C, d, rc);
    check("w1c_clear_if", d, 32'd0);
    @(negedge HCLK);
    check("w1c_clear_irq", 32'(irq[0]), 32'd0);

    for (int it = 0; it < 10; it++) begin
      lval = $urandom_range(0, 9);
      os = 1'($urandom_range(0, 1));
      w = $urandom_range(0, 25);
      wr32(0, 12'h004, lval, c);
      wr32(0, 12'h000, {29'd0, os, 2'b11}, ce);
      repeat (w) @(posedge HCLK);
      #1;
      rd32(0, 12'h008, d, rc);
      tmodel(lval, lval, os, rc - ce, v, f, e);
      check("rnd_value", d, v);
      rd32(0, 12'h00C, d, rc);
      tmodel(lval, lval, os, rc - ce, v, f, e);
      check("rnd_if", d, 32'(f));
      @(negedge HCLK);
      tmodel(lval, lval, os, cyc - ce, v, f, e);
      check("rnd_irq", 32'(irq[0]), 32'(f));
      rd32(0, 12'h000, d, rc);
      tmodel(lval, lval, os, rc - ce, v, f, e);
      check("rnd_ctrl", d, {29'd0, os, 1'b1, e});
      wr32(0, 12'h000, 32'h0, c);
      wr32(0, 12'h00C, 32'h1, c);

      v = $urandom;
      wr32(1, 12'h004, v, c);
      rd32(1, 12'h004, d, rc);
      check("rnd_ws2_load", d, v);
    end

    wr32(0, 12'h004, 32'd0, c);
    wr32(0, 12'h000, 32'h3, c);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("pre_rst_irq", 32'(irq[0]), 32'd1);

    // Reset during a stalled data phase abandons the transfer
    hsel = 2'b10;
    HTRANS = 2'b10;
    HADDR = 12'h004;
    HWRITE = 1'b0;
    HSIZE = 3'b010;
    @(posedge HCLK);
    #1;
    hsel = '0;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("mid_wait_low", 32'(rdy[1]), 32'd0);
    HRESET = 1'b1;
    @(negedge HCLK);
    for (int i = 0; i < 2; i++) begin
      check("midrst_hreadyout", 32'(rdy[i]), 32'd1);
      check("midrst_hresp", 32'(rsp[i]), 32'd0);
      check("midrst_hrdata", rdat[i], 32'd0);
      check("midrst_irq", 32'(irq[i]), 32'd0);
    end
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    rd32(1, 12'h004, d, rc);
    check("midrst_load", d, 32'd0);
    rd32(0, 12'h000, d, rc);
    check("midrst_ctrl", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
